// File: rtl/serial_add_sub_unit_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and operation-select values.
package serial_add_sub_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_unit_fa.sv
// Single-bit full adder used as the bit-slice datapath of the serial unit.
module full_adder_1bit (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic z,
    output logic cout
);

    assign z    = x ^ y ^ c;
    assign cout = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_add_sub_unit.sv
// Multi-cycle bit-serial adder/subtractor: one operand bit per cycle, LSB first,
// through a single full adder with a registered carry feedback.
module serial_add_sub_unit
    import serial_add_sub_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic             load, step, last;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_final;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_z, fa_cout;

    full_adder_1bit u_fa (
        .x    (op_a[0]),
        .y    (op_b[0]),
        .c    (carry),
        .z    (fa_z),
        .cout (fa_cout)
    );

    // res holds the WIDTH-1 bits already produced; the current adder bit
    // completes the word, so the result is available on the final edge.
    assign res_final = {fa_z, res};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            count    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= (sub == OP_SUB) ? ~b : b;
            carry <= (sub == OP_SUB);
            res   <= '0;
            count <= '0;
        end else if (step) begin
            op_a  <= {1'b0, op_a[WIDTH-1:1]};
            op_b  <= {1'b0, op_b[WIDTH-1:1]};
            res   <= res_final[WIDTH-1:1];
            carry <= fa_cout;
            count <= count + 1'b1;
            if (last) begin
                sum      <= res_final;
                cout     <= fa_cout;
                overflow <= carry ^ fa_cout;
                zero     <= (res_final == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for serial_add_sub_unit (WIDTH=32): directed vectors push
// hand-computed results; a monitor pops and compares on every done pulse.
module tb_serial_add_sub_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, cout, overflow, zero;
    logic [31:0] sum;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    serial_add_sub_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 sum=%h", sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", {31'b0, cout}, {31'b0, e.c});
                chk("overflow", {31'b0, overflow}, {31'b0, e.v});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
            end
        end
    end

    // Called at a negedge: present operands for one edge, optionally record expectation.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input bit push, input logic [31:0] es, input logic ec,
                         input logic ev, input logic ez);
        exp_t e;
        a = ia;
        b = ib;
        sub = isub;
        start = 1'b1;
        if (push) begin
            e.s = es; e.c = ec; e.v = ev; e.z = ez;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        sub = ~isub;
    endtask

    // Returns at the negedge where done is seen; checks busy lasted 32 cycles.
    task automatic wait_done(input bit inject);
        int  busy_n = 0;
        bit  ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ok = 1;
                break;
            end
            if (busy) busy_n++;
            if (inject && busy_n == 10) begin
                a = 32'd1;
                b = 32'd1;
                sub = 1'b0;
                start = 1'b1;
            end
        end
        chk("done_within_bound", {31'b0, ok}, 32'd1);
        chk("busy_cycles", busy_n, 32'd32);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'b0, busy, done, cout, overflow, zero}, 32'd0);
        chk("reset_sum", sum, 32'd0);
        reset = 1'b0;

        // Idle with toggling operands: nothing may move.
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            sub = i[0];
            @(negedge clk);
            chk("idle_flags", {27'b0, busy, done, cout, overflow, zero}, 32'd0);
            chk("idle_sum", sum, 32'd0);
        end

        issue(32'd5, 32'd3, 1'b0, 1, 32'h00000008, 0, 0, 0);
        wait_done(0);
        @(negedge clk);
        chk("done_single_cycle", {31'b0, done}, 32'd0);
        chk("sum_holds", sum, 32'h00000008);

        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 32'h00000000, 1, 0, 1);
        wait_done(0);
        @(negedge clk);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1, 32'h80000000, 0, 1, 0);
        wait_done(0);
        @(negedge clk);
        issue(32'd5, 32'd5, 1'b1, 1, 32'h00000000, 1, 0, 1);
        wait_done(0);
        @(negedge clk);
        issue(32'd3, 32'd5, 1'b1, 1, 32'hFFFFFFFE, 0, 0, 0);
        wait_done(0);
        @(negedge clk);
        issue(32'h80000000, 32'h00000001, 1'b1, 1, 32'h7FFFFFFF, 1, 1, 0);
        wait_done(0);
        @(negedge clk);

        // start pulsed mid-run must be ignored.
        issue(32'd5, 32'd3, 1'b0, 1, 32'h00000008, 0, 0, 0);
        wait_done(1);
        @(negedge clk);
        chk("no_extra_run", {31'b0, busy}, 32'd0);

        // Back-to-back: start held during DONE launches the next op at once.
        issue(32'd5, 32'd3, 1'b0, 1, 32'h00000008, 0, 0, 0);
        wait_done(0);
        issue(32'd2, 32'd2, 1'b0, 1, 32'h00000004, 0, 0, 0);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(0);
        @(negedge clk);

        // Asynchronous reset mid-operation aborts with no done.
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, '0, 0, 0, 0);
        repeat (9) @(negedge clk);
        chk("busy_before_reset", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_flags", {27'b0, busy, done, cout, overflow, zero}, 32'd0);
        chk("async_reset_sum", sum, 32'd0);
        repeat (40) @(negedge clk);
        chk("reset_hold_flags", {27'b0, busy, done, cout, overflow, zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'd7, 32'd9, 1'b0, 1, 32'h00000010, 0, 0, 0);
        wait_done(0);
        repeat (4) @(negedge clk);

        chk("done_count", done_seen, 32'd10);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
